// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order FIFO between rename and the issue queue; tags each accepted instruction
// with a nonzero sequence number. Define DISPATCH_BYPASS_EN for zero-latency empty-queue bypass.
module dispatch_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INFO_W = 170
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   STALL,
  input  logic                   FLUSH,
  input  logic                   in_valid,
  input  logic [INFO_W-1:0]      in_issueinfo,
  output logic                   in_ready,
  input  logic                   issue_halt,
  output logic                   rename_enque,
  output logic [INFO_W-1:0]      rename_issueinfo,
  output logic [31:0]            rename_instr_num,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       next_num_q, next_num_d;
  logic [INFO_W-1:0] info_mem_q [DEPTH];
  logic [31:0]       num_mem_q  [DEPTH];

  logic empty;
  logic bypass;
  logic accept;
  logic write_en;
  logic deq_en;

  // Handshake and head presentation; a bypassed instruction is numbered but never stored.
  always_comb begin
    empty = (count_q == '0);
`ifdef DISPATCH_BYPASS_EN
    bypass = empty & in_valid & ~issue_halt & ~STALL & ~FLUSH;
`else
    bypass = 1'b0;
`endif
    in_ready     = (count_q < CNT_W'(DEPTH)) & ~STALL;
    accept       = in_valid & in_ready & ~FLUSH;
    write_en     = accept & ~bypass;
    deq_en       = ~empty & ~issue_halt & ~STALL & ~FLUSH;
    rename_enque = (~empty & ~issue_halt & ~STALL) | bypass;

    rename_issueinfo = '0;
    rename_instr_num = '0;
    if (!empty) begin
      rename_issueinfo = info_mem_q[head_q];
      rename_instr_num = num_mem_q[head_q];
    end else if (bypass) begin
      rename_issueinfo = in_issueinfo;
      rename_instr_num = next_num_q;
    end
  end

  // Next-state; FLUSH empties the queue but sequence numbering carries on.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    next_num_d = next_num_q;
    if (FLUSH) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_en) begin
        head_d = head_q + PTR_W'(1);
      end
      if (write_en) begin
        tail_d = tail_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(write_en) - CNT_W'(deq_en);
      if (accept) begin
        next_num_d = (next_num_q == 32'hFFFF_FFFF) ? 32'd1 : next_num_q + 32'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      next_num_q <= 32'd1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        info_mem_q[i] <= '0;
        num_mem_q[i]  <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      next_num_q <= next_num_d;
      if (write_en) begin
        info_mem_q[tail_q] <= in_issueinfo;
        num_mem_q[tail_q]  <= next_num_q;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: table vectors, directed corner sequences and randomized traffic
// checked against a queue-based reference model of the dispatch queue.
module tb_dispatch_queue;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned INFO_W = 170;
`ifdef DISPATCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              CLK;
  logic              RESET;
  logic              STALL;
  logic              FLUSH;
  logic              in_valid;
  logic [INFO_W-1:0] in_issueinfo;
  logic              in_ready;
  logic              issue_halt;
  logic              rename_enque;
  logic [INFO_W-1:0] rename_issueinfo;
  logic [31:0]       rename_instr_num;
  logic [2:0]        count;

  dispatch_queue #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .STALL            (STALL),
    .FLUSH            (FLUSH),
    .in_valid         (in_valid),
    .in_issueinfo     (in_issueinfo),
    .in_ready         (in_ready),
    .issue_halt       (issue_halt),
    .rename_enque     (rename_enque),
    .rename_issueinfo (rename_issueinfo),
    .rename_instr_num (rename_instr_num),
    .count            (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [INFO_W-1:0] info;
    logic [31:0]       num;
  } ent_t;

  typedef struct {
    bit         v;
    logic [7:0] info;
    bit         h;
    bit         rdy;
    bit         enq;
    logic [7:0] oinfo;
    logic [31:0] onum;
    int         cnt;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  ent_t        mq[$];
  logic [31:0] m_next;
  logic [31:0] issued[$];
  vec_t        tbl[15];

  task automatic check(input string name, input logic [INFO_W-1:0] act, input logic [INFO_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_next = 32'd1;
  endtask

  // Apply one cycle of inputs, compare outputs against the model, then advance the model.
  task automatic cycle(input bit v, input logic [INFO_W-1:0] inf, input bit h, input bit s, input bit f);
    bit                e_rdy, e_enq, byp;
    logic [INFO_W-1:0] e_info;
    logic [31:0]       e_num;
    ent_t              e;
    @(negedge CLK);
    in_valid = v; in_issueinfo = inf; issue_halt = h; STALL = s; FLUSH = f;
    #1;
    byp    = BYP && mq.size() == 0 && v && !h && !s && !f;
    e_rdy  = (mq.size() < DEPTH) && !s;
    e_enq  = (mq.size() != 0 && !h && !s) || byp;
    e_info = (mq.size() != 0) ? mq[0].info : (byp ? inf : '0);
    e_num  = (mq.size() != 0) ? mq[0].num : (byp ? m_next : 32'd0);
    check("in_ready", INFO_W'(in_ready), INFO_W'(e_rdy));
    check("rename_enque", INFO_W'(rename_enque), INFO_W'(e_enq));
    check("rename_issueinfo", rename_issueinfo, e_info);
    check("rename_instr_num", INFO_W'(rename_instr_num), INFO_W'(e_num));
    check("count", INFO_W'(count), INFO_W'(mq.size()));
    if (rename_enque && !f) issued.push_back(rename_instr_num);
    @(posedge CLK);
    if (f) begin
      mq.delete();
    end else if (!s) begin
      if (mq.size() != 0 && !h) void'(mq.pop_front());
      if (v && e_rdy) begin
        if (!byp) begin
          e.info = inf;
          e.num  = m_next;
          mq.push_back(e);
        end
        m_next = (m_next == 32'hFFFF_FFFF) ? 32'd1 : m_next + 32'd1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    in_valid = 1'b0; issue_halt = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
  endtask

  function automatic logic [INFO_W-1:0] rand_info();
    logic [INFO_W-1:0] r = '0;
    for (int k = 0; k < 6; k++) r = {r[INFO_W-33:0], $urandom()};
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill with halt held, then drain in order, then accept the two held back.
    //            v  info   h  rdy enq oinfo onum cnt
    tbl[0]  = '{1, 8'h10, 1, 1, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 8'h11, 1, 1, 0, 8'h10, 1, 1};
    tbl[2]  = '{1, 8'h12, 1, 1, 0, 8'h10, 1, 2};
    tbl[3]  = '{1, 8'h13, 1, 1, 0, 8'h10, 1, 3};
    tbl[4]  = '{1, 8'h14, 1, 0, 0, 8'h10, 1, 4};
    tbl[5]  = '{1, 8'h14, 1, 0, 0, 8'h10, 1, 4};
    tbl[6]  = '{0, 8'h00, 0, 0, 1, 8'h10, 1, 4};
    tbl[7]  = '{0, 8'h00, 0, 1, 1, 8'h11, 2, 3};
    tbl[8]  = '{0, 8'h00, 0, 1, 1, 8'h12, 3, 2};
    tbl[9]  = '{0, 8'h00, 0, 1, 1, 8'h13, 4, 1};
    tbl[10] = '{1, 8'h14, 1, 1, 0, 8'h00, 0, 0};
    tbl[11] = '{1, 8'h15, 1, 1, 0, 8'h14, 5, 1};
    tbl[12] = '{0, 8'h00, 0, 1, 1, 8'h14, 5, 2};
    tbl[13] = '{0, 8'h00, 0, 1, 1, 8'h15, 6, 1};
    tbl[14] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 0};

    RESET = 1'b1; STALL = 1'b1; FLUSH = 1'b0;
    in_valid = 1'b0; in_issueinfo = '0; issue_halt = 1'b0;
    model_reset();

    // Reset state
    @(posedge CLK);
    #1;
    check("rst_ready_stalled", INFO_W'(in_ready), INFO_W'(0));
    check("rst_enque", INFO_W'(rename_enque), INFO_W'(0));
    check("rst_info", rename_issueinfo, '0);
    check("rst_num", INFO_W'(rename_instr_num), INFO_W'(0));
    check("rst_count", INFO_W'(count), INFO_W'(0));
    STALL = 1'b0;
    #1;
    check("rst_ready", INFO_W'(in_ready), INFO_W'(1));
    @(negedge CLK);
    RESET = 1'b0;

    // Table vectors
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      in_valid = tbl[i].v; in_issueinfo = INFO_W'(tbl[i].info); issue_halt = tbl[i].h;
      #1;
      check($sformatf("tbl%0d.ready", i), INFO_W'(in_ready), INFO_W'(tbl[i].rdy));
      check($sformatf("tbl%0d.enque", i), INFO_W'(rename_enque), INFO_W'(tbl[i].enq));
      check($sformatf("tbl%0d.info", i), rename_issueinfo, INFO_W'(tbl[i].oinfo));
      check($sformatf("tbl%0d.num", i), INFO_W'(rename_instr_num), INFO_W'(tbl[i].onum));
      check($sformatf("tbl%0d.count", i), INFO_W'(count), INFO_W'(tbl[i].cnt));
    end

    // Back-to-back A,B,C with no halt
    do_reset();
    issued.delete();
    cycle(1, INFO_W'(8'hA1), 0, 0, 0);
    cycle(1, INFO_W'(8'hB2), 0, 0, 0);
    cycle(1, INFO_W'(8'hC3), 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0);
    check("abc_issued", INFO_W'(issued.size()), INFO_W'(3));
    for (int i = 0; i < 3 && i < issued.size(); i++)
      check($sformatf("abc_num%0d", i), INFO_W'(issued[i]), INFO_W'(i + 1));
    check("abc_count", INFO_W'(count), INFO_W'(0));

    // Flush with two entries and a valid input
    do_reset();
    cycle(1, INFO_W'(8'h21), 1, 0, 0);
    cycle(1, INFO_W'(8'h22), 1, 0, 0);
    cycle(1, INFO_W'(8'h23), 0, 0, 1);
    #1;
    check("flush_count", INFO_W'(count), INFO_W'(0));
    check("flush_enque", INFO_W'(rename_enque), INFO_W'(0));
    cycle(1, INFO_W'(8'h24), 1, 0, 0);
    #1;
    check("flush_next_num", INFO_W'(rename_instr_num), INFO_W'(3));

    // Stall with entries present and a valid input
    cycle(1, INFO_W'(8'h25), 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, INFO_W'(8'h26), 0, 1, 0);
    #1;
    check("stall_count", INFO_W'(count), INFO_W'(2));
    check("stall_head_num", INFO_W'(rename_instr_num), INFO_W'(3));
    for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0);

    // Sequence number wrap skips zero
    @(negedge CLK);
    force dut.next_num_q = 32'hFFFF_FFFF;
    #1;
    release dut.next_num_q;
    m_next = 32'hFFFF_FFFF;
    issued.delete();
    cycle(1, INFO_W'(8'h31), 1, 0, 0);
    cycle(1, INFO_W'(8'h32), 1, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    check("wrap_issued", INFO_W'(issued.size()), INFO_W'(2));
    if (issued.size() == 2) begin
      check("wrap_first", INFO_W'(issued[0]), INFO_W'(32'hFFFF_FFFF));
      check("wrap_second", INFO_W'(issued[1]), INFO_W'(1));
    end

    // Asynchronous reset mid-transfer drops everything
    cycle(1, INFO_W'(8'h41), 1, 0, 0);
    cycle(1, INFO_W'(8'h42), 1, 0, 0);
    @(negedge CLK);
    in_valid = 1'b1; issue_halt = 1'b0;
    #2;
    RESET = 1'b1;
    #1;
    check("midrst_count", INFO_W'(count), INFO_W'(0));
    check("midrst_enque", INFO_W'(rename_enque), INFO_W'(0));
    check("midrst_info", rename_issueinfo, '0);
    check("midrst_num", INFO_W'(rename_instr_num), INFO_W'(0));
    @(negedge CLK);
    RESET = 1'b0; in_valid = 1'b0;
    model_reset();
    #1;
    check("midrst_count_after", INFO_W'(count), INFO_W'(0));

    // First-instruction latency into an empty queue
    do_reset();
    @(negedge CLK);
    in_valid = 1'b1; in_issueinfo = INFO_W'(8'h5A); issue_halt = 1'b0;
    #1;
    if (BYP) begin
      check("byp_enque", INFO_W'(rename_enque), INFO_W'(1));
      check("byp_info", rename_issueinfo, INFO_W'(8'h5A));
      check("byp_num", INFO_W'(rename_instr_num), INFO_W'(1));
      @(posedge CLK);
      #1;
      check("byp_count", INFO_W'(count), INFO_W'(0));
    end else begin
      check("lat_same_cycle_enque", INFO_W'(rename_enque), INFO_W'(0));
      @(posedge CLK);
      #1;
      check("lat_next_enque", INFO_W'(rename_enque), INFO_W'(1));
      check("lat_next_info", rename_issueinfo, INFO_W'(8'h5A));
      check("lat_next_num", INFO_W'(rename_instr_num), INFO_W'(1));
      check("lat_next_count", INFO_W'(count), INFO_W'(1));
    end
    @(negedge CLK);
    in_valid = 1'b0;
    do_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom_range(99) < 70), rand_info(), ($urandom_range(99) < 30),
            ($urandom_range(99) < 10), ($urandom_range(99) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
